rrat_mc: RTL and testbench

- Retirement register alias table with COMMIT_WIDTH commit lanes per cycle. Holds the committed arch-to-physical mapping and returns the displaced physical register of each commit to the free list.
- Adds a flush-recovery walker. After a pipeline flush it streams the full committed map to the speculative RAT, RECOVER_WIDTH entries per beat, using a valid/ready handshake.
- Sits between ROB commit and the free list / front-end RAT.

---
 rtl/rrat_mc.sv | 124 ++++++++++++
 tb/tb_rrat_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrat_mc.sv
// Retirement register alias table: multi-lane commit with same-cycle frees of displaced
// physical registers, plus a valid/ready walker that streams the committed map after a flush.
module rrat_mc #(
    parameter  int ARCH_REGS     = 32,
    parameter  int PHYS_BITS     = 6,
    parameter  int COMMIT_WIDTH  = 2,
    parameter  int RECOVER_WIDTH = 8,
    localparam int AIDX          = $clog2(ARCH_REGS),
    localparam int BEATS         = ARCH_REGS / RECOVER_WIDTH,
    localparam int BEAT_BITS     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [COMMIT_WIDTH-1:0]                  commit_valid,
    input  logic [COMMIT_WIDTH-1:0][AIDX-1:0]        commit_rd,
    input  logic [COMMIT_WIDTH-1:0][PHYS_BITS-1:0]   commit_pd,
    output logic                                     commit_ready,
    output logic [COMMIT_WIDTH-1:0]                  free_valid,
    output logic [COMMIT_WIDTH-1:0][PHYS_BITS-1:0]   free_preg,
    input  logic                                     flush_req,
    output logic                                     recov_valid,
    input  logic                                     recov_ready,
    output logic [AIDX-1:0]                          recov_base,
    output logic [RECOVER_WIDTH-1:0][PHYS_BITS-1:0]  recov_pd,
    output logic                                     recov_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [BEAT_BITS-1:0]    r_beat;
    logic [PHYS_BITS-1:0]    r_table [ARCH_REGS];
    logic [COMMIT_WIDTH-1:0] w_active;
    logic [AIDX-1:0]         w_base;
    logic                    w_fire;
    logic                    w_last_beat;

    assign commit_ready = (r_state == S_IDLE) && !rst;
    assign w_fire       = recov_valid && recov_ready;
    assign w_last_beat  = (r_beat == BEAT_BITS'(BEATS - 1));
    assign w_base       = AIDX'(int'(r_beat) * RECOVER_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A flush in WALK restarts the walk; a flush in DONE chains straight into a new walk.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (flush_req) w_next_state = S_WALK;
            S_WALK: begin
                if (flush_req)                 w_next_state = S_WALK;
                else if (w_fire && w_last_beat) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = flush_req ? S_WALK : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a value before the case/loop so no latch is inferred.
        recov_valid = (r_state == S_WALK);
        recov_done  = (r_state == S_DONE);
        recov_base  = w_base;
        for (int k = 0; k < RECOVER_WIDTH; k++) begin
            recov_pd[k] = r_table[w_base + AIDX'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
        end else if (r_state == S_WALK) begin
            if (flush_req) begin
                r_beat <= '0;
            end else if (w_fire) begin
                r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
            end
        end
    end

    // An older lane with the same rd displaces its own pd to the younger lane, not the table value.
    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_active[i] = commit_valid[i] && commit_ready && (commit_rd[i] != '0);
        end
        free_valid = w_active;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            free_preg[i] = r_table[commit_rd[i]];
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (j < i && w_active[j] && (commit_rd[j] == commit_rd[i])) begin
                    free_preg[i] = commit_pd[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is a flop array, not a RAM, so resetting it to identity is legal and required.
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_table[i] <= PHYS_BITS'(i);
            end
        end else begin
            // NOTE: non-blocking writes in lane order let the youngest lane's write to a shared rd win.
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (w_active[i]) begin
                    r_table[commit_rd[i]] <= commit_pd[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rrat_mc.sv
// Self-checking bench for rrat_mc: random commits and walks checked against a sequential
// program-order model of the committed map.
module tb_rrat_mc;

    localparam int AR    = 32;
    localparam int PB    = 6;
    localparam int CW    = 2;
    localparam int RW    = 8;
    localparam int AIDX  = 5;
    localparam int BEATS = AR / RW;

    typedef logic [CW-1:0][AIDX-1:0] rd_vec_t;
    typedef logic [CW-1:0][PB-1:0]   pd_vec_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [CW-1:0]           commit_valid;
    rd_vec_t                 commit_rd;
    pd_vec_t                 commit_pd;
    logic                    commit_ready;
    logic [CW-1:0]           free_valid;
    pd_vec_t                 free_preg;
    logic                    flush_req;
    logic                    recov_valid;
    logic                    recov_ready;
    logic [AIDX-1:0]         recov_base;
    logic [RW-1:0][PB-1:0]   recov_pd;
    logic                    recov_done;

    int total = 0;
    int bad   = 0;

    logic [PB-1:0] mtab [AR];

    rrat_mc #(
        .ARCH_REGS    (AR),
        .PHYS_BITS    (PB),
        .COMMIT_WIDTH (CW),
        .RECOVER_WIDTH(RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .commit_valid(commit_valid),
        .commit_rd   (commit_rd),
        .commit_pd   (commit_pd),
        .commit_ready(commit_ready),
        .free_valid  (free_valid),
        .free_preg   (free_preg),
        .flush_req   (flush_req),
        .recov_valid (recov_valid),
        .recov_ready (recov_ready),
        .recov_base  (recov_base),
        .recov_pd    (recov_pd),
        .recov_done  (recov_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < AR; i++) mtab[i] = PB'(i);
    endtask

    task automatic idle_inputs();
        commit_valid = '0;
        commit_rd    = '0;
        commit_pd    = '0;
        flush_req    = 1'b0;
        recov_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One IDLE cycle of commits (optionally with flush_req); frees come from the program-order model.
    task automatic drive_commit(input logic [CW-1:0] v, input rd_vec_t rd, input pd_vec_t pd,
                                input bit fl, input string tag);
        logic [CW-1:0] efv;
        pd_vec_t       efp;
        commit_valid = v;
        commit_rd    = rd;
        commit_pd    = pd;
        flush_req    = fl;
        #1;
        efv = '0;
        efp = '0;
        for (int i = 0; i < CW; i++) begin
            if (v[i] && rd[i] != '0) begin
                efv[i]        = 1'b1;
                efp[i]        = mtab[rd[i]];
                mtab[rd[i]]   = pd[i];
            end
        end
        total++;
        if (commit_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s commit_ready: got %0b exp 1", tag, commit_ready);
        end
        total++;
        if (free_valid !== efv) begin
            bad++;
            $display("FAIL %s free_valid: got %b exp %b", tag, free_valid, efv);
        end
        for (int i = 0; i < CW; i++) begin
            if (efv[i]) begin
                total++;
                if (free_preg[i] !== efp[i]) begin
                    bad++;
                    $display("FAIL %s free_preg[%0d]: got %0d exp %0d", tag, i, free_preg[i], efp[i]);
                end
            end
        end
        tick();
        idle_inputs();
    endtask

    // Runs a walk from beat 0 until all beats are accepted; mode 0 ready=1, 1 pattern 1,0,0, 2 random.
    task automatic run_beats(input int mode, input bit noise, input int abort_at);
        int beat    = 0;
        int cycles  = 0;
        int pat     = 0;
        bit aborted = 1'b0;
        bit rdy;
        while (beat < BEATS && cycles < 200) begin
            case (mode)
                1:       rdy = (pat % 3 == 0);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            pat++;
            recov_ready = rdy;
            flush_req   = (beat == abort_at) && !aborted;
            if (noise) begin
                commit_valid = CW'($urandom);
                commit_rd    = (CW * AIDX)'($urandom);
                commit_pd    = (CW * PB)'($urandom);
            end
            #1;
            total++;
            if (recov_valid !== 1'b1 || recov_done !== 1'b0) begin
                bad++;
                $display("FAIL walk valid/done beat %0d: got %b%b exp 10", beat, recov_valid, recov_done);
            end
            total++;
            if (recov_base !== AIDX'(beat * RW)) begin
                bad++;
                $display("FAIL walk base: got %0d exp %0d", recov_base, beat * RW);
            end
            total++;
            if (commit_ready !== 1'b0 || free_valid !== '0) begin
                bad++;
                $display("FAIL walk commit blocked: got ready=%0b free=%b exp 0/00", commit_ready, free_valid);
            end
            for (int k = 0; k < RW; k++) begin
                total++;
                if (recov_pd[k] !== mtab[beat * RW + k]) begin
                    bad++;
                    $display("FAIL walk pd x%0d: got %0d exp %0d", beat * RW + k, recov_pd[k], mtab[beat * RW + k]);
                end
            end
            if (flush_req) begin
                beat    = 0;
                aborted = 1'b1;
            end else if (rdy) begin
                beat++;
            end
            tick();
            cycles++;
        end
        idle_inputs();
        if (beat < BEATS) begin
            total++;
            bad++;
            $display("FAIL walk timeout: got %0d beats exp %0d", beat, BEATS);
        end
    endtask

    task automatic expect_done(input bit reflush);
        flush_req = reflush;
        #1;
        total++;
        if (recov_done !== 1'b1 || recov_valid !== 1'b0 || commit_ready !== 1'b0) begin
            bad++;
            $display("FAIL done pulse: got done=%0b valid=%0b ready=%0b exp 1/0/0", recov_done, recov_valid, commit_ready);
        end
        tick();
        flush_req = 1'b0;
        if (!reflush) begin
            #1;
            total++;
            if (recov_done !== 1'b0 || recov_valid !== 1'b0 || commit_ready !== 1'b1) begin
                bad++;
                $display("FAIL after done: got done=%0b valid=%0b ready=%0b exp 0/0/1", recov_done, recov_valid, commit_ready);
            end
        end
    endtask

    task automatic run_walk(input int mode, input bit noise, input int abort_at);
        drive_commit('0, '0, '0, 1'b1, "flush");
        run_beats(mode, noise, abort_at);
        expect_done(1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (commit_ready !== 1'b1 || recov_valid !== 1'b0 || recov_done !== 1'b0 || free_valid !== '0) begin
            bad++;
            $display("FAIL reset outputs: got ready=%0b valid=%0b done=%0b free=%b exp 1/0/0/00",
                     commit_ready, recov_valid, recov_done, free_valid);
        end
    endtask

    task automatic test_reset_walk();
        run_walk(0, 1'b0, -1);
    endtask

    task automatic test_two_lanes();
        drive_commit(2'b11, {5'd7, 5'd3}, {6'd41, 6'd40}, 1'b0, "two_lanes");
        run_walk(0, 1'b0, -1);
    endtask

    task automatic test_same_rd();
        drive_commit(2'b11, {5'd5, 5'd5}, {6'd34, 6'd33}, 1'b0, "same_rd");
        run_walk(0, 1'b0, -1);
    endtask

    task automatic test_rd0();
        drive_commit(2'b01, {5'd0, 5'd0}, {6'd0, 6'd50}, 1'b0, "rd0_lane0");
        drive_commit(2'b11, {5'd0, 5'd12}, {6'd51, 6'd52}, 1'b0, "rd0_lane1");
        run_walk(0, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        run_walk(1, 1'b1, -1);
        run_walk(2, 1'b1, -1);
    endtask

    task automatic test_mid_walk_flush();
        run_walk(0, 1'b0, 2);
        run_walk(1, 1'b1, 1);
    endtask

    task automatic test_flush_in_done();
        drive_commit('0, '0, '0, 1'b1, "flush_done");
        run_beats(0, 1'b0, -1);
        expect_done(1'b1);
        run_beats(2, 1'b0, -1);
        expect_done(1'b0);
    endtask

    task automatic test_random_commits();
        for (int n = 0; n < 60; n++) begin
            drive_commit(CW'($urandom), {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                         (CW * PB)'($urandom), 1'b0, "random");
        end
        run_walk(2, 1'b0, -1);
    endtask

    task automatic test_commit_flush_rst();
        drive_commit(2'b01, {5'd0, 5'd9}, {6'd0, 6'd60}, 1'b1, "commit_flush");
        for (int b = 0; b < 2; b++) begin
            recov_ready = 1'b1;
            #1;
            total++;
            if (recov_base !== AIDX'(b * RW) || recov_pd[1] !== mtab[b * RW + 1]) begin
                bad++;
                $display("FAIL rst_walk beat %0d: got base=%0d pd1=%0d exp %0d/%0d",
                         b, recov_base, recov_pd[1], b * RW, mtab[b * RW + 1]);
            end
            if (b == 1) begin
                total++;
                if (recov_pd[1] !== 6'd60) begin
                    bad++;
                    $display("FAIL x9 after flush commit: got %0d exp 60", recov_pd[1]);
                end
            end
            tick();
        end
        rst         = 1'b1;
        recov_ready = 1'b1;
        #1;
        total++;
        if (recov_valid !== 1'b1 || recov_base !== AIDX'(2 * RW)) begin
            bad++;
            $display("FAIL rst_walk beat2: got valid=%0b base=%0d exp 1/16", recov_valid, recov_base);
        end
        tick();
        total++;
        if (recov_valid !== 1'b0 || recov_done !== 1'b0) begin
            bad++;
            $display("FAIL rst mid-walk: got valid=%0b done=%0b exp 0/0", recov_valid, recov_done);
        end
        rst = 1'b0;
        idle_inputs();
        model_reset();
        tick();
        total++;
        if (recov_valid !== 1'b0 || recov_done !== 1'b0 || commit_ready !== 1'b1) begin
            bad++;
            $display("FAIL after rst release: got valid=%0b done=%0b ready=%0b exp 0/0/1",
                     recov_valid, recov_done, commit_ready);
        end
        run_walk(0, 1'b0, -1);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_reset_walk();
        test_two_lanes();
        test_same_rd();
        test_rd0();
        test_backpressure();
        test_mid_walk_flush();
        test_flush_in_done();
        test_random_commits();
        test_commit_flush_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
